// File: rtl/lc3b_types.sv
// Shared LC-3b cache types: line/select widths, cache FSM states and a byte-merge helper.
package lc3b_types;

    localparam int CACHE_OFFSET_BITS = 4;

    typedef logic [127:0] lc3b_cache_line;
    typedef logic [15:0]  lc3b_cache_sel;

    typedef enum logic [1:0] {
        IDLE,
        RESPOND,
        WRITEBACK,
        FILL
    } cache_state_e;

    function automatic lc3b_cache_line merge_bytes(input lc3b_cache_line line,
                                                   input lc3b_cache_sel  sel,
                                                   input lc3b_cache_line wdat);
        lc3b_cache_line r;
        r = line;
        for (int b = 0; b < 16; b++)
            if (sel[b]) r[8*b +: 8] = wdat[8*b +: 8];
        return r;
    endfunction

endpackage

// File: rtl/l1_cache_control.sv
// L1 cache FSM: decides hit/miss handling, drives array load enables and registered wishbone strobes.
// Optional hit/miss counters under L1_CACHE_STATS_EN.
module l1_cache_control
    import lc3b_types::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic        hit,
    input  logic        dirty,
    input  logic        mem_ack,
    output logic        cpu_ack,
    output logic        mem_cyc,
    output logic        mem_stb,
    output logic        mem_we,
    output logic        rd_load,
    output logic        wr_load,
    output logic        fill_load,
    output logic        wb_done,
    output logic        nxt_wb,
    output logic        nxt_fill
`ifdef L1_CACHE_STATS_EN
    ,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
`endif
);

    cache_state_e state, state_nxt;
    logic         mem_act;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            mem_act <= 1'b0;
            mem_we  <= 1'b0;
        end else begin
            state   <= state_nxt;
            mem_act <= nxt_wb | nxt_fill;
            mem_we  <= nxt_wb;
        end
    end

    always_comb begin
        state_nxt = state;
        rd_load   = 1'b0;
        wr_load   = 1'b0;
        fill_load = 1'b0;
        wb_done   = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        state_nxt = RESPOND;
                        rd_load   = !we;
                        wr_load   = we;
                    end else if (dirty) begin
                        state_nxt = WRITEBACK;
                    end else begin
                        state_nxt = FILL;
                    end
                end
            end
            // The CPU still holds its strobe here; returning to IDLE without looking avoids re-accepting it.
            RESPOND: state_nxt = IDLE;
            WRITEBACK: begin
                if (mem_ack) begin
                    wb_done   = 1'b1;
                    state_nxt = FILL;
                end
            end
            FILL: begin
                if (mem_ack) begin
                    fill_load = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign nxt_wb   = (state_nxt == WRITEBACK);
    assign nxt_fill = (state_nxt == FILL);
    assign cpu_ack  = (state == RESPOND);
    assign mem_cyc  = mem_act;
    assign mem_stb  = mem_act;

`ifdef L1_CACHE_STATS_EN
    logic after_fill;
    logic hit_evt;
    logic miss_evt;

    // A hit that directly follows a fill is the same request finishing, not a new hit.
    assign hit_evt  = (state == IDLE) && (state_nxt == RESPOND) && !after_fill;
    assign miss_evt = (state == IDLE) && (nxt_wb || nxt_fill);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            after_fill <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (state == FILL && state_nxt == IDLE)
                after_fill <= 1'b1;
            else if (state == RESPOND || (state == IDLE && !req))
                after_fill <= 1'b0;
            if (hit_evt && hit_count != 16'hFFFF)
                hit_count <= hit_count + 16'd1;
            if (miss_evt && miss_count != 16'hFFFF)
                miss_count <= miss_count + 16'd1;
        end
    end
`endif

endmodule

// File: rtl/l1_cache.sv
// Direct-mapped write-back/write-allocate L1 cache with 128-bit line wishbone memory port.
// Define L1_CACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module l1_cache
    import lc3b_types::*;
#(
    parameter int INDEX_BITS = 3
)
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cpu_cyc,
    input  logic         cpu_stb,
    input  logic         cpu_we,
    input  logic [15:0]  cpu_sel,
    input  logic [15:0]  cpu_adr,
    input  logic [127:0] cpu_dat_m,
    output logic [127:0] cpu_dat_s,
    output logic         cpu_ack,
    output logic         mem_cyc,
    output logic         mem_stb,
    output logic         mem_we,
    output logic [15:0]  mem_sel,
    output logic [15:0]  mem_adr,
    output logic [127:0] mem_dat_m,
    input  logic [127:0] mem_dat_s,
    input  logic         mem_ack
`ifdef L1_CACHE_STATS_EN
    ,
    output logic [15:0]  hit_count,
    output logic [15:0]  miss_count
`endif
);

    localparam int NUM_LINES = 1 << INDEX_BITS;
    localparam int TAG_BITS  = 16 - CACHE_OFFSET_BITS - INDEX_BITS;

    logic [TAG_BITS-1:0]   req_tag;
    logic [INDEX_BITS-1:0] idx;
    logic                  hit, line_dirty;
    logic                  rd_load, wr_load, fill_load, wb_done, nxt_wb, nxt_fill;
    logic                  unused_offset;

    lc3b_cache_line        data_arr [NUM_LINES];
    logic [TAG_BITS-1:0]   tag_arr  [NUM_LINES];
    logic [NUM_LINES-1:0]  valid_arr, dirty_arr;

    assign req_tag       = cpu_adr[15:CACHE_OFFSET_BITS+INDEX_BITS];
    assign idx           = cpu_adr[CACHE_OFFSET_BITS+INDEX_BITS-1:CACHE_OFFSET_BITS];
    assign unused_offset = ^cpu_adr[CACHE_OFFSET_BITS-1:0];

    assign hit        = valid_arr[idx] && (tag_arr[idx] == req_tag);
    assign line_dirty = valid_arr[idx] && dirty_arr[idx];

    l1_cache_control u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (cpu_cyc & cpu_stb),
        .we        (cpu_we),
        .hit       (hit),
        .dirty     (line_dirty),
        .mem_ack   (mem_ack),
        .cpu_ack   (cpu_ack),
        .mem_cyc   (mem_cyc),
        .mem_stb   (mem_stb),
        .mem_we    (mem_we),
        .rd_load   (rd_load),
        .wr_load   (wr_load),
        .fill_load (fill_load),
        .wb_done   (wb_done),
        .nxt_wb    (nxt_wb),
        .nxt_fill  (nxt_fill)
`ifdef L1_CACHE_STATS_EN
        ,
        .hit_count (hit_count),
        .miss_count(miss_count)
`endif
    );

    // Data and tag storage carry no reset; valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (fill_load) begin
            data_arr[idx] <= mem_dat_s;
            tag_arr[idx]  <= req_tag;
        end else if (wr_load) begin
            data_arr[idx] <= merge_bytes(data_arr[idx], cpu_sel, cpu_dat_m);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_arr <= '0;
            dirty_arr <= '0;
            cpu_dat_s <= '0;
            mem_adr   <= '0;
            mem_dat_m <= '0;
            mem_sel   <= '0;
        end else begin
            if (fill_load) begin
                valid_arr[idx] <= 1'b1;
                dirty_arr[idx] <= 1'b0;
            end
            if (wr_load) dirty_arr[idx] <= 1'b1;
            if (wb_done) dirty_arr[idx] <= 1'b0;
            if (rd_load) cpu_dat_s <= data_arr[idx];

            // Memory-side outputs are registered off the next state so they hold steady per cycle.
            if (nxt_wb) begin
                mem_adr   <= {tag_arr[idx], idx, {CACHE_OFFSET_BITS{1'b0}}};
                mem_dat_m <= data_arr[idx];
                mem_sel   <= 16'hFFFF;
            end else if (nxt_fill) begin
                mem_adr   <= {req_tag, idx, {CACHE_OFFSET_BITS{1'b0}}};
                mem_dat_m <= '0;
                mem_sel   <= 16'hFFFF;
            end else begin
                mem_adr   <= '0;
                mem_dat_m <= '0;
                mem_sel   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_l1_cache.sv
// Self-checking bench for l1_cache: directed vector table, reset-during-fill sequence, and
// randomized traffic checked against a flat-memory golden image plus a tag/valid/dirty model.
module tb_l1_cache;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cpu_cyc = 1'b0, cpu_stb = 1'b0, cpu_we = 1'b0;
    logic [15:0]  cpu_sel = '0, cpu_adr = '0;
    logic [127:0] cpu_dat_m = '0, cpu_dat_s;
    logic         cpu_ack;
    logic         mem_cyc, mem_stb, mem_we;
    logic [15:0]  mem_sel, mem_adr;
    logic [127:0] mem_dat_m;
    logic [127:0] mem_dat_s = '0;
    logic         mem_ack = 1'b0;
`ifdef L1_CACHE_STATS_EN
    logic [15:0]  hit_count, miss_count;
`endif

    l1_cache #(.INDEX_BITS(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_cyc(cpu_cyc), .cpu_stb(cpu_stb), .cpu_we(cpu_we), .cpu_sel(cpu_sel),
        .cpu_adr(cpu_adr), .cpu_dat_m(cpu_dat_m), .cpu_dat_s(cpu_dat_s), .cpu_ack(cpu_ack),
        .mem_cyc(mem_cyc), .mem_stb(mem_stb), .mem_we(mem_we), .mem_sel(mem_sel),
        .mem_adr(mem_adr), .mem_dat_m(mem_dat_m), .mem_dat_s(mem_dat_s), .mem_ack(mem_ack)
`ifdef L1_CACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- memory slave ----------------
    logic [127:0] mline [int];
    typedef struct {logic we; logic [15:0] adr; logic [127:0] dat;} mtxn_t;
    mtxn_t mlog[$];
    int lat = 1;
    bit hold_ack = 1'b0;
    int mcnt = 0;

    function automatic logic [127:0] pat(input logic [15:0] a);
        return {4{a, ~a}};
    endfunction

    function automatic logic [127:0] mem_rd(input logic [15:0] a);
        return mline.exists(int'(a)) ? mline[int'(a)] : pat(a);
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (mem_ack) begin
                mem_ack = 1'b0;
                mcnt = 0;
            end else if (mem_cyc && mem_stb && !hold_ack && rst_n) begin
                mcnt++;
                if (mcnt >= lat) begin
                    mtxn_t t;
                    t.we  = mem_we;
                    t.adr = mem_adr;
                    t.dat = mem_we ? mem_dat_m : mem_rd(mem_adr);
                    if (mem_we) mline[int'(mem_adr)] = mem_dat_m;
                    else        mem_dat_s = t.dat;
                    mlog.push_back(t);
                    mem_ack = 1'b1;
                    check("mem sel/align", {mem_sel, mem_adr[3:0]}, {16'hFFFF, 4'h0});
                end
            end else begin
                mcnt = 0;
            end
        end
    end

    // ---------------- CPU-side helpers ----------------
    task automatic do_req(input logic we, input logic [15:0] adr, input logic [15:0] sel,
                          input logic [127:0] dat, output logic [127:0] rd, output int lat_o);
        bit ok;
        @(negedge clk);
        check("ack single pulse", cpu_ack, 1'b0);
        cpu_cyc = 1'b1; cpu_stb = 1'b1; cpu_we = we;
        cpu_adr = adr; cpu_sel = sel; cpu_dat_m = dat;
        lat_o = 0; ok = 1'b0; rd = '0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk);
            lat_o++;
            @(negedge clk);
            if (cpu_ack) begin
                ok = 1'b1;
                rd = cpu_dat_s;
                break;
            end
        end
        lat_o++;  // the CPU samples the ack on the following edge
        cpu_cyc = 1'b0; cpu_stb = 1'b0;
        if (!ok) begin
            n_tests++; n_fail++;
            $display("FAIL ack timeout: adr %h got no ack required ack", adr);
        end
    endtask

    task automatic check_log(input string nm, input int ewb, input logic [15:0] wadr,
                             input logic [127:0] wdat, input int efill, input logic [15:0] fadr);
        check({nm, " txn count"}, mlog.size(), ewb + efill);
        if (mlog.size() == ewb + efill) begin
            if (ewb != 0) begin
                check({nm, " wb we"},  mlog[0].we,  1'b1);
                check({nm, " wb adr"}, mlog[0].adr, wadr);
                check({nm, " wb dat"}, mlog[0].dat, wdat);
            end
            if (efill != 0) begin
                check({nm, " fill we"},  mlog[ewb].we,  1'b0);
                check({nm, " fill adr"}, mlog[ewb].adr, fadr);
            end
        end
        mlog.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; cpu_cyc = 1'b0; cpu_stb = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic we; logic [15:0] adr; logic [15:0] sel; logic [127:0] dat;
        logic [127:0] exp_rd; int exp_lat;
        int exp_wb; logic [15:0] wb_adr; logic [127:0] wb_dat;
        int exp_fill; logic [15:0] fill_adr;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [15:0] adr, input logic [15:0] sel,
                                input logic [127:0] dat, input logic [127:0] rd, input int l,
                                input int wb, input logic [15:0] wa, input logic [127:0] wd,
                                input int fl, input logic [15:0] fa);
        vec_t v;
        v.we = we; v.adr = adr; v.sel = sel; v.dat = dat; v.exp_rd = rd; v.exp_lat = l;
        v.exp_wb = wb; v.wb_adr = wa; v.wb_dat = wd; v.exp_fill = fl; v.fill_adr = fa;
        return v;
    endfunction

    vec_t tbl[11];
    logic [127:0] rd_v;
    int lat_v;

    // ---------------- random reference model ----------------
    logic [127:0] gline [int];
    bit           m_val   [8];
    bit           m_dirty [8];
    logic [15:0]  m_tag   [8];

    function automatic logic [127:0] gold_rd(input logic [15:0] a);
        return gline.exists(int'(a)) ? gline[int'(a)] : mem_rd(a);
    endfunction

    initial begin
        logic [127:0] aa, bee, c3, m1000;
        aa    = {8{16'hAAAA}};
        bee   = {{5{16'hAAAA}}, 16'hBEEF, {2{16'hAAAA}}};
        c3    = {8{16'h3C3C}};
        m1000 = {{6{16'h3C3C}}, 32'h12345678};
        mline[16'h0040] = aa;
        mline[16'h0440] = {8{16'h5555}};
        mline[16'h1000] = c3;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset ctrl", {cpu_ack, mem_cyc, mem_stb, mem_we}, 4'h0);
        check("reset sel/adr", {mem_sel, mem_adr}, 32'h0);
        check("reset mem_dat_m", mem_dat_m, 128'h0);
        check("reset cpu_dat_s", cpu_dat_s, 128'h0);
`ifdef L1_CACHE_STATS_EN
        check("reset counters", {hit_count, miss_count}, 32'h0);
`endif
        rst_n = 1'b1;

        tbl[0]  = mk(0, 16'h0040, 16'h0000, '0, aa, 4, 0, 0, 0, 1, 16'h0040);
        tbl[1]  = mk(0, 16'h0042, 16'h0000, '0, aa, 2, 0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 16'h0044, 16'h0030, {80'h0, 16'hBEEF, 32'h0}, 0, 2, 0, 0, 0, 0, 0);
        tbl[3]  = mk(0, 16'h0040, 16'h0000, '0, bee, 2, 0, 0, 0, 0, 0);
        tbl[4]  = mk(0, 16'h0440, 16'h0000, '0, {8{16'h5555}}, 6, 1, 16'h0040, bee, 1, 16'h0440);
        tbl[5]  = mk(1, 16'h1000, 16'h000F, {96'h0, 32'h12345678}, 0, 4, 0, 0, 0, 1, 16'h1000);
        tbl[6]  = mk(0, 16'h1000, 16'h0000, '0, m1000, 2, 0, 0, 0, 0, 0);
        tbl[7]  = mk(0, 16'h0070, 16'h0000, '0, pat(16'h0070), 4, 0, 0, 0, 1, 16'h0070);
        tbl[8]  = mk(1, 16'h0070, 16'h0000, {128{1'b1}}, 0, 2, 0, 0, 0, 0, 0);
        tbl[9]  = mk(0, 16'h0470, 16'h0000, '0, pat(16'h0470), 6, 1, 16'h0070, pat(16'h0070), 1, 16'h0470);
        tbl[10] = mk(0, 16'h0000, 16'h0000, '0, pat(16'h0000), 6, 1, 16'h1000, m1000, 1, 16'h0000);

        lat = 1;
        for (int i = 0; i < 11; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            do_req(tbl[i].we, tbl[i].adr, tbl[i].sel, tbl[i].dat, rd_v, lat_v);
            check({nm, " latency"}, lat_v, tbl[i].exp_lat);
            if (!tbl[i].we) check({nm, " rdata"}, rd_v, tbl[i].exp_rd);
            check_log(nm, tbl[i].exp_wb, tbl[i].wb_adr, tbl[i].wb_dat, tbl[i].exp_fill, tbl[i].fill_adr);
`ifdef L1_CACHE_STATS_EN
            if (i == 3) check("stats 1 miss 3 hits", {miss_count, hit_count}, {16'd1, 16'd3});
`endif
        end

        // reset while a fill is outstanding
        hold_ack = 1'b1;
        @(negedge clk);
        cpu_cyc = 1'b1; cpu_stb = 1'b1; cpu_we = 1'b0; cpu_adr = 16'h0200; cpu_sel = '0;
        for (int c = 0; c < 20 && !mem_cyc; c++) @(negedge clk);
        check("fill started", {mem_cyc, mem_we, mem_adr}, {1'b1, 1'b0, 16'h0200});
        rst_n = 1'b0; cpu_cyc = 1'b0; cpu_stb = 1'b0;
        @(negedge clk);
        check("reset aborts fill", {mem_cyc, mem_stb, cpu_ack}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        hold_ack = 1'b0;
        check_log("aborted", 0, 0, 0, 0, 0);
        do_req(0, 16'h0200, '0, '0, rd_v, lat_v);
        check("reread after reset rdata", rd_v, pat(16'h0200));
        check_log("reread after reset", 0, 0, 0, 1, 16'h0200);
        do_req(0, 16'h0470, '0, '0, rd_v, lat_v);
        check("old line invalid after reset", lat_v, 4);
        check_log("old line after reset", 0, 0, 0, 1, 16'h0470);
        @(negedge clk);
        check("mem idle after fill", {mem_cyc, mem_stb}, 2'b00);

        // randomized traffic vs. golden memory image
        do_reset();
        mlog.delete();
        gline.delete();
        foreach (mline[k]) gline[k] = mline[k];
        for (int i = 0; i < 8; i++) begin m_val[i] = 0; m_dirty[i] = 0; m_tag[i] = '0; end

        for (int n = 0; n < 200; n++) begin
            int tg, ix, off, elat, ewb;
            logic        we;
            logic [15:0] adr, la, sel;
            logic [127:0] dat, line, wdat;
            bit hit;
            tg  = $urandom_range(0, 3);
            ix  = $urandom_range(0, 7);
            off = $urandom_range(0, 15);
            adr = 16'((tg << 7) | (ix << 4) | off);
            la  = adr & 16'hFFF0;
            we  = 1'($urandom_range(0, 1));
            sel = 16'($urandom);
            dat = {$urandom, $urandom, $urandom, $urandom};
            lat = $urandom_range(1, 3);

            hit  = m_val[ix] && (m_tag[ix] == la);
            ewb  = (!hit && m_val[ix] && m_dirty[ix]) ? 1 : 0;
            wdat = gold_rd(m_tag[ix]);
            elat = hit ? 2 : ((ewb != 0) ? lat + 1 : 0) + lat + 3;

            do_req(we, adr, sel, dat, rd_v, lat_v);
            check($sformatf("rnd%0d latency", n), lat_v, elat);
            if (!we) check($sformatf("rnd%0d rdata", n), rd_v, gold_rd(la));
            check_log($sformatf("rnd%0d", n), ewb, m_tag[ix], wdat, hit ? 0 : 1, la);

            if (we) begin
                line = gold_rd(la);
                for (int b = 0; b < 16; b++)
                    if (sel[b]) line[8*b +: 8] = dat[8*b +: 8];
                gline[int'(la)] = line;
            end
            if (!hit) m_dirty[ix] = 0;
            if (we)   m_dirty[ix] = 1;
            m_val[ix] = 1;
            m_tag[ix] = la;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout: simulation still running, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/l1_cache.md
Name: l1_cache

Overview:
- Direct-mapped, write-back, write-allocate L1 cache for the LC-3b core.
- Sits directly downstream of the cpu wishbone master (cpu_to_cache) and upstream of main memory.
- Memory side is a 128-bit line-granular wishbone master (cache_to_mem).
- CPU side accepts 16-bit addresses with byte-lane SEL over a 128-bit data bus; the CPU has already shifted its data into the correct lane.

Parameters:
INDEX_BITS, 3, line index width; 2**INDEX_BITS lines; tag width = 12-INDEX_BITS (offset is ADR[3:0]).

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
cpu_cyc  input  1  CPU cycle valid
cpu_stb  input  1  CPU strobe
cpu_we  input  1  1=write, 0=read
cpu_sel  input  16  byte enables within line
cpu_adr  input  16  byte address
cpu_dat_m  input  128  write data, lane-aligned
cpu_dat_s  output  128  read data, whole line
cpu_ack  output  1  one-cycle completion pulse
mem_cyc  output  1  memory cycle valid
mem_stb  output  1  memory strobe
mem_we  output  1  1=writeback, 0=fill
mem_sel  output  16  always 16'hFFFF when mem_stb=1, else 0
mem_adr  output  16  line-aligned address, [3:0]=0
mem_dat_m  output  128  evicted line
mem_dat_s  input  128  fill line
mem_ack  input  1  memory completion

Behaviour:
- Reset (rst_n=0 at posedge):
  - all valid and dirty bits cleared; FSM to IDLE.
  - outputs cpu_ack, mem_cyc, mem_stb, mem_we, mem_sel = 0; mem_adr, mem_dat_m, cpu_dat_s = 0.
- Reset mid-operation: any in-flight memory cycle is abandoned (mem_cyc drops next cycle) and the CPU request is not acked.
- Address split: tag=cpu_adr[15:4+INDEX_BITS], index=cpu_adr[3+INDEX_BITS:4].
- Hit condition: valid[index] && tag_array[index]==tag.
- Request acceptance: a request is only sampled in IDLE with cpu_cyc&cpu_stb.
- FSM states: IDLE, RESPOND, WRITEBACK, FILL.
- IDLE:
  - read hit: cpu_dat_s <= line; -> RESPOND.
  - write hit: for each byte b with cpu_sel[b]=1, line[8b+7:8b] <= cpu_dat_m[8b+7:8b]; dirty <= 1; -> RESPOND.
  - miss with valid&dirty: -> WRITEBACK.
  - miss otherwise: -> FILL.
- RESPOND:
  - cpu_ack=1 for exactly one cycle; -> IDLE.
  - cpu_stb is ignored in this cycle, so no double-accept of a request the CPU is still holding.
- WRITEBACK:
  - mem_cyc=mem_stb=mem_we=1; mem_adr={old_tag,index,4'b0}; mem_dat_m=line.
  - hold until mem_ack; on mem_ack: dirty <= 0, -> FILL.
- FILL:
  - mem_cyc=mem_stb=1, mem_we=0; mem_adr={tag,index,4'b0}.
  - on mem_ack: line <= mem_dat_s, tag written, valid <= 1, dirty <= 0; -> IDLE.
  - the still-held CPU request then re-evaluates as a hit, which merges write data for write misses.
- Latency:
  - hit: ack 2 cycles after request sampled.
  - clean miss: fill ack latency + 3.
  - dirty miss: adds writeback latency + 1.
- Memory side outputs are registered; mem_stb and mem_cyc fall in the cycle after mem_ack.
- Boundary: the lowest (index 0) and highest (index 2**INDEX_BITS-1) lines behave identically. A tag mismatch on an invalid line never triggers writeback.
- cpu_sel=0 write hit: no data change, dirty still set, still acked.

Optional Feature:
- Macro: L1_CACHE_STATS_EN.
- When defined, adds outputs hit_count (16, output) and miss_count (16, output).
  - hit_count increments on each IDLE->RESPOND transition that was not preceded by a FILL for the same request.
  - miss_count increments on each IDLE->WRITEBACK/FILL transition.
  - both saturate at 16'hFFFF and clear on reset.
- When undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package lc3b_types gains:
  - lc3b_cache_line (logic [127:0]);
  - lc3b_cache_sel (logic [15:0]);
  - cache state enum (IDLE, RESPOND, WRITEBACK, FILL);
  - constant CACHE_OFFSET_BITS=4.
- One sub-module, l1_cache_control: the FSM, taking hit/dirty/mem_ack/cpu_stb and driving the array load enables and wishbone strobes.
- Arrays and muxing live in l1_cache.

Test Plan:
- Reset then read 16'h0040 with memory returning line 128'h...AAAA -> one FILL with mem_adr=16'h0040, mem_we=0; cpu_ack once; cpu_dat_s equals the fill line.
- Repeat read of 16'h0042 -> no memory activity; cpu_ack exactly 2 cycles after the request.
- Write 16'h0044 sel=16'h0030, data 16'hBEEF in bytes 4-5 -> hit, dirty set. Then read 16'h0440 (same index, INDEX_BITS=3) -> WRITEBACK at 16'h0040 with bytes 5:4=16'hBEEF, then FILL at 16'h0440.
- Write miss to 16'h1000 -> FILL from 16'h1000, then merge; subsequent read shows written bytes, others from memory.
- Assert rst_n=0 during FILL with mem_ack withheld -> mem_cyc=0 next cycle, no cpu_ack; a re-read of the same address misses again.
- With L1_CACHE_STATS_EN: 1 miss then 3 hits -> miss_count=1, hit_count=3.
